// File: rtl/icache_fetch_pkg.sv
// Shared constants for the instruction-fetch cache: widths, memory-port
// encodings and FSM state codes.
package icache_fetch_pkg;

  localparam int unsigned addrWidth = 32;
  localparam int unsigned instWidth = 32;

  localparam logic [1:0] MEM_READ     = 2'b10;
  localparam logic [1:0] MEM_NOP      = 2'b00;
  localparam logic [1:0] MEM_LEN_WORD = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/icache_fetch_array.sv
// Direct-mapped tag/data store with a valid vector: combinational lookup,
// synchronous fill, single-cycle clear of every valid bit.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned TAG_W      = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  input  logic [TAG_W-1:0]      rd_tag_i,
  output logic                  rd_hit_o,
  output logic [instWidth-1:0]  rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [instWidth-1:0]  wr_data_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [instWidth-1:0] data_q [LINES];

  // Clear takes priority so a fill racing a flush never survives it.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch cache controller: IDLE/REQ/WAIT miss FSM, address latch
// and flush drop flag. Define ICACHE_STATS_EN to add hit/miss counter ports.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [1:0]        mem_rw_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_len,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  drop_q, drop_d;
  logic                  if_valid_q, if_valid_d;
  logic [instWidth-1:0]  if_inst_q, if_inst_d;
  logic                  fill_we;

  logic [ADDR_W-1:0]     req_addr;
  logic [INDEX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0]      lk_tag, fill_tag;
  logic                  lk_hit;
  logic [instWidth-1:0]  lk_data;

  assign req_addr = if_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign lk_idx   = req_addr[INDEX_BITS+1:2];
  assign lk_tag   = req_addr[ADDR_W-1:INDEX_BITS+2];
  assign fill_idx = addr_q[INDEX_BITS+1:2];
  assign fill_tag = addr_q[ADDR_W-1:INDEX_BITS+2];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (flush),
    .rd_idx_i  (lk_idx),
    .rd_tag_i  (lk_tag),
    .rd_hit_o  (lk_hit),
    .rd_data_o (lk_data),
    .wr_en_i   (fill_we),
    .wr_idx_i  (fill_idx),
    .wr_tag_i  (fill_tag),
    .wr_data_i (mem_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    if_valid_d = 1'b0;
    if_inst_d  = if_inst_q;
    fill_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req && !flush) begin
          if (lk_hit) begin
            if_valid_d = 1'b1;
            if_inst_d  = lk_data;
          end else begin
            addr_d  = req_addr;
            state_d = ST_REQ;
          end
        end
      end
      // The read is already on the port this cycle, so a flush here must
      // still wait out the controller's completion and discard it.
      ST_REQ: begin
        state_d = ST_WAIT;
        if (flush) drop_d = 1'b1;
      end
      ST_WAIT: begin
        if (flush) drop_d = 1'b1;
        if (mem_done) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !flush) begin
            fill_we    = 1'b1;
            if_valid_d = 1'b1;
            if_inst_d  = mem_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign mem_rw_flag = (state_q == ST_REQ) ? MEM_READ : MEM_NOP;
  assign mem_addr    = addr_q;
  assign mem_len     = MEM_LEN_WORD;

  // Cycles since the read was issued without the controller reporting busy.
  logic [1:0] busy_age_q;

  always_ff @(posedge clk) begin
    if (rst || mem_busy) begin
      busy_age_q <= '0;
    end else if (state_q == ST_REQ || busy_age_q != '0) begin
      busy_age_q <= busy_age_q + 2'd1;
    end
  end

  a_busy_follows_req: assert property (@(posedge clk) disable iff (rst)
    busy_age_q != 2'd3);

`ifdef ICACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign hit_evt  = (state_q == ST_IDLE) && if_req && !flush && lk_hit;
  assign miss_evt = (state_q == ST_IDLE) && if_req && !flush && !lk_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: table of fetches plus hand-written
// flush, reset and back-to-back sequences.
module tb_icache_fetch;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic        mem_busy;
  logic        mem_done;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_fetch #(
    .INDEX_BITS (7),
    .ADDR_W     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .mem_rw_flag (mem_rw_flag),
    .mem_addr    (mem_addr),
    .mem_len     (mem_len),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done),
    .mem_data    (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (addr %h): got %h, expected %h", name, cur_addr, act, exp);
    end
  endtask

  // Called right after a falling edge; returns right after a falling edge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input bit miss);
    cur_addr = addr;
    if_req   = 1'b1;
    if_addr  = addr;
    @(negedge clk);
    if (miss) begin
      chk("req_flag", 32'(mem_rw_flag), 32'h2);
      chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("req_len", 32'(mem_len), 32'h3);
      chk("no_early_valid", 32'(if_valid), 32'd0);
      mem_busy = 1'b1;
      @(negedge clk);
      chk("req_one_cycle", 32'(mem_rw_flag), 32'h0);
      @(negedge clk);
      mem_done = 1'b1;
      mem_data = word;
      @(negedge clk);
      mem_done = 1'b0;
      mem_busy = 1'b0;
    end else begin
      chk("hit_no_mem", 32'(mem_rw_flag), 32'h0);
    end
    chk("valid", 32'(if_valid), 32'd1);
    chk("inst", if_inst, word);
    if_req = 1'b0;
    @(negedge clk);
    chk("single_pulse", 32'(if_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    bit          miss;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] bb_addr [5];
  logic [31:0] bb_word [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{32'h0000_0010, 32'h00A0_0093, 1'b1};
    tbl[1]  = '{32'h0000_0010, 32'h00A0_0093, 1'b0};
    tbl[2]  = '{32'h0000_0013, 32'h00A0_0093, 1'b0};
    tbl[3]  = '{32'h0000_0014, 32'h0010_0113, 1'b1};
    tbl[4]  = '{32'h0000_0018, 32'h0020_0193, 1'b1};
    tbl[5]  = '{32'h0000_001C, 32'h0030_0213, 1'b1};
    tbl[6]  = '{32'h0000_0020, 32'h0040_0293, 1'b1};
    tbl[7]  = '{32'h0000_0210, 32'hDEAD_BEEF, 1'b1};
    tbl[8]  = '{32'h0000_0210, 32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{32'h0000_0010, 32'h00A0_0093, 1'b1};
    tbl[10] = '{32'h0000_01FC, 32'hCAFE_F00D, 1'b1};
    tbl[11] = '{32'hFFFF_FFFC, 32'h1234_5678, 1'b1};
    tbl[12] = '{32'h0000_01FC, 32'hCAFE_F00D, 1'b1};
    tbl[13] = '{32'h0000_0000, 32'h0000_0013, 1'b1};
    tbl[14] = '{32'h0000_01FC, 32'hCAFE_F00D, 1'b0};

    bb_addr[0] = 32'h10; bb_word[0] = 32'h00A0_0093;
    bb_addr[1] = 32'h14; bb_word[1] = 32'h0010_0113;
    bb_addr[2] = 32'h18; bb_word[2] = 32'h0020_0193;
    bb_addr[3] = 32'h1C; bb_word[3] = 32'h0030_0213;
    bb_addr[4] = 32'h20; bb_word[4] = 32'h0040_0293;

    cur_addr = '0;
    rst      = 1'b1;
    flush    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    mem_busy = 1'b0;
    mem_done = 1'b0;
    mem_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_flag", 32'(mem_rw_flag), 32'h0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_len", 32'(mem_len), 32'h3);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      fetch(tbl[i].addr, tbl[i].word, tbl[i].miss);
    end

    // Five warmed lines fetched back-to-back, one per cycle.
    if_req  = 1'b1;
    if_addr = bb_addr[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cur_addr = bb_addr[i];
      chk("b2b_valid", 32'(if_valid), 32'd1);
      chk("b2b_inst", if_inst, bb_word[i]);
      chk("b2b_no_mem", 32'(mem_rw_flag), 32'h0);
      if (i < 4) if_addr = bb_addr[i+1];
      else       if_req  = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end", 32'(if_valid), 32'd0);

    // Flush while waiting: the completion is swallowed.
    cur_addr = 32'h400;
    if_req   = 1'b1;
    if_addr  = 32'h400;
    @(negedge clk);
    chk("wflush_req", 32'(mem_rw_flag), 32'h2);
    mem_busy = 1'b1;
    @(negedge clk);
    flush  = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("wflush_valid0", 32'(if_valid), 32'd0);
    @(negedge clk);
    mem_done = 1'b1;
    mem_data = 32'h0050_0313;
    @(negedge clk);
    mem_done = 1'b0;
    mem_busy = 1'b0;
    chk("wflush_drop", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("wflush_after", 32'(if_valid), 32'd0);
    chk("wflush_idle", 32'(mem_rw_flag), 32'h0);
    fetch(32'h400, 32'h0050_0313, 1'b1);
    fetch(32'h14, 32'h0010_0113, 1'b1);

    // Flush alongside a would-be hit.
    cur_addr = 32'h14;
    if_req   = 1'b1;
    if_addr  = 32'h14;
    flush    = 1'b1;
    @(negedge clk);
    chk("fhit_valid", 32'(if_valid), 32'd0);
    chk("fhit_flag", 32'(mem_rw_flag), 32'h0);
    flush  = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    chk("fhit_after", 32'(if_valid), 32'd0);
    fetch(32'h400, 32'h0050_0313, 1'b1);
    fetch(32'h14, 32'h0010_0113, 1'b1);

    // Flush in the same cycle as the completion.
    cur_addr = 32'h800;
    if_req   = 1'b1;
    if_addr  = 32'h800;
    @(negedge clk);
    chk("fdone_req", 32'(mem_rw_flag), 32'h2);
    mem_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_done = 1'b1;
    mem_data = 32'h0060_0393;
    flush    = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    mem_busy = 1'b0;
    flush    = 1'b0;
    if_req   = 1'b0;
    chk("fdone_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("fdone_after", 32'(if_valid), 32'd0);
    fetch(32'h800, 32'h0060_0393, 1'b1);
    fetch(32'h14, 32'h0010_0113, 1'b1);

    // Flush while the read is on the port.
    cur_addr = 32'hC00;
    if_req   = 1'b1;
    if_addr  = 32'hC00;
    @(negedge clk);
    chk("freq_req", 32'(mem_rw_flag), 32'h2);
    flush    = 1'b1;
    mem_busy = 1'b1;
    if_req   = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("freq_no_reissue", 32'(mem_rw_flag), 32'h0);
    @(negedge clk);
    mem_done = 1'b1;
    mem_data = 32'h0070_0413;
    @(negedge clk);
    mem_done = 1'b0;
    mem_busy = 1'b0;
    chk("freq_drop", 32'(if_valid), 32'd0);
    fetch(32'hC00, 32'h0070_0413, 1'b1);

    // Reset in the middle of a miss.
    cur_addr = 32'h1000;
    if_req   = 1'b1;
    if_addr  = 32'h1000;
    @(negedge clk);
    chk("rmid_req", 32'(mem_rw_flag), 32'h2);
    mem_busy = 1'b1;
    @(negedge clk);
    rst      = 1'b1;
    if_req   = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_flag", 32'(mem_rw_flag), 32'h0);
    chk("rmid_valid", 32'(if_valid), 32'd0);
    chk("rmid_addr", mem_addr, 32'd0);
    chk("rmid_inst", if_inst, 32'd0);
    @(negedge clk);
    chk("rmid_idle", 32'(mem_rw_flag), 32'h0);
    fetch(32'hC00, 32'h0070_0413, 1'b1);

`ifdef ICACHE_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stat_rst_hit", hit_cnt, 32'd0);
    chk("stat_rst_miss", miss_cnt, 32'd0);
    fetch(32'h10, 32'h00A0_0093, 1'b1);
    fetch(32'h14, 32'h0010_0113, 1'b1);
    fetch(32'h18, 32'h0020_0193, 1'b1);
    fetch(32'h10, 32'h00A0_0093, 1'b0);
    fetch(32'h14, 32'h0010_0113, 1'b0);
    fetch(32'h18, 32'h0020_0193, 1'b0);
    fetch(32'h10, 32'h00A0_0093, 1'b0);
    chk("stat_hit", hit_cnt, 32'd4);
    chk("stat_miss", miss_cnt, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("stat_flush_hit", hit_cnt, 32'd4);
    chk("stat_flush_miss", miss_cnt, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stat_clr_hit", hit_cnt, 32'd0);
    chk("stat_clr_miss", miss_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
